inst_fetch_unit: RTL and testbench

Instruction fetch stage of the single-cycle CPU, directly upstream of the main control decoder. It holds the program counter, fetches each instruction from instruction memory over a request/acknowledge handshake, and presents the instruction to the rest of the core. Its `opcode` output drives the decoder. It consumes the decoder's `Branch`/`JMP` outputs and the ALU zero flag to select the next PC.

---
 rtl/inst_fetch_unit.sv | 110 +++++++++++
 tb/tb_inst_fetch_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack handshake,
// and picks the next PC from the decoder's jump/branch outputs and the ALU zero flag.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        branch,
    input  logic        zero,
    input  logic        jmp,
    input  logic        stall,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    output logic        fetch_err,
    output logic [31:0] retired
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_EXEC,
        S_HALT
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_retired;
    logic        r_fetchErr;
    logic [7:0]  r_tmoCount;

    logic [31:0] w_pcPlus4;
    logic [31:0] w_branchTarget;
    logic [31:0] w_jumpTarget;
    logic [31:0] w_nextPc;

    assign w_pcPlus4      = r_pc + 32'd4;
    assign w_branchTarget = w_pcPlus4 + {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
    assign w_jumpTarget   = {w_pcPlus4[31:28], r_instr[25:0], 2'b00};

    // Jump outranks a taken branch when the decoder raises both.
    always_comb begin
        w_nextPc = w_pcPlus4;
        if (jmp) begin
            w_nextPc = w_jumpTarget;
        end else if (branch && zero) begin
            w_nextPc = w_branchTarget;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_FETCH;
            r_pc       <= {RESET_PC[31:2], 2'b00};
            r_instr    <= 32'd0;
            r_retired  <= 32'd0;
            r_fetchErr <= 1'b0;
            r_tmoCount <= 8'd0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem_ack) begin
                        r_instr    <= imem_rdata;
                        r_tmoCount <= 8'd0;
                        r_state    <= S_EXEC;
                    end else if (r_tmoCount == TMO_LAST) begin
                        r_fetchErr <= 1'b1;
                        r_state    <= S_HALT;
                    end else begin
                        r_tmoCount <= r_tmoCount + 8'd1;
                    end
                end
                S_EXEC: begin
                    if (!stall) begin
                        r_pc      <= {w_nextPc[31:2], 2'b00};
                        r_retired <= r_retired + 32'd1;
                        r_state   <= S_FETCH;
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_HALT;
                end
            endcase
        end
    end

    // Gating with rst_n drops the request the instant reset asserts.
    assign imem_req    = rst_n && (r_state == S_FETCH);
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign pc_plus4    = w_pcPlus4;
    assign instr       = r_instr;
    assign opcode      = r_instr[31:26];
    assign instr_valid = (r_state == S_EXEC);
    assign fetch_err   = r_fetchErr;
    assign retired     = r_retired;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed self-checking bench for inst_fetch_unit; a second instance with a
// high RESET_PC exercises the jump target's upper-nibble handling.
module tb_inst_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        branch;
    logic        zero;
    logic        jmp;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic        fetch_err;
    logic [31:0] retired;

    logic        jAck;
    logic [31:0] jRdata;
    logic        jBranch;
    logic        jZero;
    logic        jJmp;
    logic        jReq;
    logic [31:0] jAddr;
    logic [31:0] jPc;
    logic [31:0] jPcPlus4;
    logic [31:0] jInstr;
    logic [5:0]  jOpcode;
    logic        jValid;
    logic        jErr;
    logic [31:0] jRetired;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    inst_fetch_unit #(.RESET_PC(32'h0000_0040), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .branch(branch), .zero(zero), .jmp(jmp), .stall(stall),
        .pc(pc), .pc_plus4(pc_plus4), .instr(instr), .opcode(opcode),
        .instr_valid(instr_valid), .fetch_err(fetch_err), .retired(retired)
    );

    inst_fetch_unit #(.RESET_PC(32'h1000_0000), .TIMEOUT(16)) dutJmp (
        .clk(clk), .rst_n(rst_n),
        .imem_req(jReq), .imem_addr(jAddr),
        .imem_ack(jAck), .imem_rdata(jRdata),
        .branch(jBranch), .zero(jZero), .jmp(jJmp), .stall(stall),
        .pc(jPc), .pc_plus4(jPcPlus4), .instr(jInstr), .opcode(jOpcode),
        .instr_valid(jValid), .fetch_err(jErr), .retired(jRetired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Starting at a negedge in FETCH: ack after 'delay' idle cycles, then one EXEC cycle.
    task automatic runInstr(input int delay, input logic [31:0] word,
                            input logic br, input logic z, input logic j);
        imem_ack = 1'b0;
        repeat (delay) @(negedge clk);
        imem_ack = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack = 1'b0;
        branch = br; zero = z; jmp = j;
        @(negedge clk);
        branch = 1'b0; zero = 1'b0; jmp = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (pc !== 32'h40) begin errors++; $display("[TB] FAIL reset_pc got %h exp %h", pc, 32'h40); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req got %b exp 0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b exp 0", instr_valid); end
        checks++; if (retired !== 32'd0) begin errors++; $display("[TB] FAIL reset_retired got %h exp 0", retired); end
        checks++; if (instr !== 32'd0 || fetch_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_instr_err got %h/%b exp 0/0", instr, fetch_err); end
        rst_n = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin errors++; $display("[TB] FAIL release_req got %b/%h exp 1/00000040", imem_req, imem_addr); end
    endtask

    task automatic test_jump_over_branch;
        jAck = 1'b1;
        jRdata = 32'h0800_0010;
        @(negedge clk);
        jAck = 1'b0;
        checks++; if (jValid !== 1'b1 || jOpcode !== 6'h02) begin errors++; $display("[TB] FAIL jmp_exec got %b/%h exp 1/02", jValid, jOpcode); end
        jBranch = 1'b1; jZero = 1'b1; jJmp = 1'b1;
        @(negedge clk);
        jBranch = 1'b0; jZero = 1'b0; jJmp = 1'b0;
        checks++; if (jPc !== 32'h1000_0040) begin errors++; $display("[TB] FAIL jmp_target got %h exp 10000040", jPc); end
        checks++; if (jRetired !== 32'd1 || jPcPlus4 !== 32'h1000_0044) begin errors++; $display("[TB] FAIL jmp_retire got %h/%h exp 1/10000044", jRetired, jPcPlus4); end
    endtask

    task automatic test_straight_line;
        int start;
        logic [31:0] expPc;
        start = cyc;
        for (int i = 0; i < 4; i++) begin
            expPc = 32'h40 + 32'(4 * i);
            checks++; if (pc !== expPc || imem_req !== 1'b1) begin errors++; $display("[TB] FAIL straight_pc%0d got %h/%b exp %h/1", i, pc, imem_req, expPc); end
            runInstr(0, 32'h0000_0100 + 32'(i), 1'b0, 1'b0, 1'b0);
        end
        checks++; if (pc !== 32'h50 || pc_plus4 !== 32'h54) begin errors++; $display("[TB] FAIL straight_end_pc got %h/%h exp 00000050/00000054", pc, pc_plus4); end
        checks++; if (retired !== 32'd4) begin errors++; $display("[TB] FAIL straight_retired got %0d exp 4", retired); end
        checks++; if (cyc - start !== 8) begin errors++; $display("[TB] FAIL straight_cycles got %0d exp 8", cyc - start); end
        checks++; if (instr !== 32'h0000_0103) begin errors++; $display("[TB] FAIL straight_instr got %h exp 00000103", instr); end
    endtask

    task automatic test_ack_delay;
        int start;
        start = cyc;
        imem_ack = 1'b0;
        imem_rdata = 32'h5555_5555;
        for (int k = 0; k < 3; k++) begin
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h50) begin errors++; $display("[TB] FAIL delay_addr%0d got %b/%h exp 1/00000050", k, imem_req, imem_addr); end
            @(negedge clk);
        end
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h50) begin errors++; $display("[TB] FAIL delay_addr3 got %b/%h exp 1/00000050", imem_req, imem_addr); end
        @(negedge clk);
        imem_ack = 1'b0;
        imem_rdata = 32'h1234_5678;
        checks++; if (instr !== 32'hDEAD_BEEF || opcode !== 6'h37) begin errors++; $display("[TB] FAIL delay_instr got %h/%h exp deadbeef/37", instr, opcode); end
        checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b0 || fetch_err !== 1'b0) begin errors++; $display("[TB] FAIL delay_exec got v%b r%b e%b exp v1 r0 e0", instr_valid, imem_req, fetch_err); end
        @(negedge clk);
        checks++; if (instr_valid !== 1'b0 || pc !== 32'h54) begin errors++; $display("[TB] FAIL delay_next got %b/%h exp 0/00000054", instr_valid, pc); end
        checks++; if (retired !== 32'd5 || cyc - start !== 5) begin errors++; $display("[TB] FAIL delay_count got %0d/%0d exp 5/5", retired, cyc - start); end
    endtask

    task automatic test_branch;
        runInstr(0, 32'h0800_0040, 1'b0, 1'b0, 1'b1);
        checks++; if (pc !== 32'h100) begin errors++; $display("[TB] FAIL br_setup_jmp got %h exp 00000100", pc); end
        runInstr(0, 32'h1000_FFFF, 1'b1, 1'b1, 1'b0);
        checks++; if (pc !== 32'h100) begin errors++; $display("[TB] FAIL br_neg1 got %h exp 00000100", pc); end
        runInstr(0, 32'h1000_0003, 1'b1, 1'b1, 1'b0);
        checks++; if (pc !== 32'h110) begin errors++; $display("[TB] FAIL br_pos3 got %h exp 00000110", pc); end
        runInstr(0, 32'h1000_FFFB, 1'b1, 1'b1, 1'b0);
        checks++; if (pc !== 32'h100) begin errors++; $display("[TB] FAIL br_back got %h exp 00000100", pc); end
        runInstr(0, 32'h1000_0003, 1'b1, 1'b0, 1'b0);
        checks++; if (pc !== 32'h104) begin errors++; $display("[TB] FAIL br_not_taken got %h exp 00000104", pc); end
        runInstr(0, 32'h1000_0003, 1'b0, 1'b1, 1'b0);
        checks++; if (pc !== 32'h108) begin errors++; $display("[TB] FAIL br_zero_only got %h exp 00000108", pc); end
        checks++; if (retired !== 32'd11) begin errors++; $display("[TB] FAIL br_retired got %0d exp 11", retired); end
    endtask

    task automatic test_stall;
        int execCycles;
        execCycles = 0;
        imem_ack = 1'b1;
        imem_rdata = 32'hAC00_1234;
        @(negedge clk);
        stall = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        for (int k = 0; k < 3; k++) begin
            if (instr_valid === 1'b1) execCycles++;
            checks++; if (pc !== 32'h108 || instr !== 32'hAC00_1234 || retired !== 32'd11) begin errors++; $display("[TB] FAIL stall_hold%0d got %h/%h/%0d exp 00000108/ac001234/11", k, pc, instr, retired); end
            @(negedge clk);
        end
        imem_ack = 1'b0;
        stall = 1'b0;
        if (instr_valid === 1'b1) execCycles++;
        @(negedge clk);
        checks++; if (execCycles !== 4) begin errors++; $display("[TB] FAIL stall_exec_len got %0d exp 4", execCycles); end
        checks++; if (instr_valid !== 1'b0 || pc !== 32'h10C || retired !== 32'd12) begin errors++; $display("[TB] FAIL stall_release got %b/%h/%0d exp 0/0000010c/12", instr_valid, pc, retired); end
        checks++; if (instr !== 32'hAC00_1234) begin errors++; $display("[TB] FAIL stall_ack_ignored got %h exp ac001234", instr); end
    endtask

    task automatic test_retire_wrap;
        force dut.r_retired = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.r_retired;
        checks++; if (retired !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL wrap_preset got %h exp ffffffff", retired); end
        runInstr(0, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
        checks++; if (retired !== 32'd0 || pc !== 32'h110) begin errors++; $display("[TB] FAIL wrap_zero got %h/%h exp 00000000/00000110", retired, pc); end
    endtask

    task automatic test_timeout;
        imem_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin errors++; $display("[TB] FAIL tmo_wait%0d got %b/%b exp 1/0", k, imem_req, fetch_err); end
        end
        @(negedge clk);
        checks++; if (imem_req !== 1'b0 || fetch_err !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL tmo_halt got r%b e%b v%b exp r0 e1 v0", imem_req, fetch_err, instr_valid); end
        imem_ack = 1'b1;
        imem_rdata = 32'hCAFE_F00D;
        repeat (2) @(negedge clk);
        imem_ack = 1'b0;
        checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'd0 || pc !== 32'h110) begin errors++; $display("[TB] FAIL tmo_late_ack got r%b v%b %h %h exp r0 v0 00000000 00000110", imem_req, instr_valid, instr, pc); end
    endtask

    task automatic test_reset_mid;
        rst_n = 1'b0;
        #1;
        checks++; if (pc !== 32'h40 || fetch_err !== 1'b0 || imem_req !== 1'b0 || retired !== 32'd0) begin errors++; $display("[TB] FAIL halt_reset got %h e%b r%b %0d exp 00000040 e0 r0 0", pc, fetch_err, imem_req, retired); end
        @(negedge clk);
        rst_n = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = 32'h1111_1111;
        @(negedge clk);
        imem_ack = 1'b0;
        checks++; if (instr_valid !== 1'b1 || instr !== 32'h1111_1111) begin errors++; $display("[TB] FAIL mid_exec got %b/%h exp 1/11111111", instr_valid, instr); end
        rst_n = 1'b0;
        #1;
        checks++; if (instr_valid !== 1'b0 || retired !== 32'd0 || pc !== 32'h40 || instr !== 32'd0) begin errors++; $display("[TB] FAIL mid_reset got v%b %0d %h %h exp v0 0 00000040 00000000", instr_valid, retired, pc, instr); end
        @(negedge clk);
        rst_n = 1'b1;
        runInstr(0, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
        checks++; if (retired !== 32'd1 || pc !== 32'h44) begin errors++; $display("[TB] FAIL post_reset_retire got %0d/%h exp 1/00000044", retired, pc); end
    endtask

    initial begin
        rst_n = 1'b0;
        imem_ack = 1'b0; imem_rdata = 32'd0;
        branch = 1'b0; zero = 1'b0; jmp = 1'b0; stall = 1'b0;
        jAck = 1'b0; jRdata = 32'd0;
        jBranch = 1'b0; jZero = 1'b0; jJmp = 1'b0;
        test_reset();
        test_jump_over_branch();
        test_straight_line();
        test_ack_delay();
        test_branch();
        test_stall();
        test_retire_wrap();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
